// File: rtl/systolic_mac_pe_pkg.sv
// Shared types, default widths and the saturating adder for the systolic MAC array.
// The adder works at SYS_MAX_W bits and clamps to the caller's accumulator width.
package systolic_pkg;

    typedef enum logic [1:0] {ACC, DRAIN, OUT} mac_state_t;

    localparam int SYS_DATA_W = 16;
    localparam int SYS_ACC_W  = 40;
    localparam int SYS_MAX_W  = 64;

    // Operands must already be sign-extended from a w-bit value; w <= SYS_MAX_W.
    function automatic logic signed [SYS_MAX_W-1:0] sat_add(
        input logic signed [SYS_MAX_W-1:0] a,
        input logic signed [SYS_MAX_W-1:0] b,
        input int                          w
    );
        logic signed [SYS_MAX_W:0] sum;
        logic signed [SYS_MAX_W:0] hi;
        logic signed [SYS_MAX_W:0] lo;
        sum = $signed({a[SYS_MAX_W-1], a}) + $signed({b[SYS_MAX_W-1], b});
        hi  = ((SYS_MAX_W+1)'(1) <<< (w - 1)) - (SYS_MAX_W+1)'(1);
        lo  = -((SYS_MAX_W+1)'(1) <<< (w - 1));
        if (sum > hi) begin
            sum = hi;
        end else if (sum < lo) begin
            sum = lo;
        end
        return sum[SYS_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/systolic_mac_pe_if.sv
// Operand, forwarding and result handshakes of one systolic MAC cell.
// master = the environment driving operands; slave = the processing element.
interface systolic_mac_pe_if #(
    parameter int DATA_W = systolic_pkg::SYS_DATA_W,
    parameter int ACC_W  = systolic_pkg::SYS_ACC_W
);
    logic [DATA_W-1:0] a_data;
    logic              a_valid;
    logic              a_last;
    logic [DATA_W-1:0] b_data;
    logic              b_valid;
    logic              b_last;
    logic              in_ready;

    logic [DATA_W-1:0] a_fwd_data;
    logic              a_fwd_valid;
    logic              a_fwd_last;
    logic              a_fwd_ready;
    logic [DATA_W-1:0] b_fwd_data;
    logic              b_fwd_valid;
    logic              b_fwd_last;
    logic              b_fwd_ready;

    logic [ACC_W-1:0]  c_data;
    logic              c_valid;
    logic              c_ready;
    logic              err_last_mismatch;

    modport master (
        output a_data, a_valid, a_last, b_data, b_valid, b_last,
        output a_fwd_ready, b_fwd_ready, c_ready,
        input  in_ready,
        input  a_fwd_data, a_fwd_valid, a_fwd_last,
        input  b_fwd_data, b_fwd_valid, b_fwd_last,
        input  c_data, c_valid, err_last_mismatch
    );

    modport slave (
        input  a_data, a_valid, a_last, b_data, b_valid, b_last,
        input  a_fwd_ready, b_fwd_ready, c_ready,
        output in_ready,
        output a_fwd_data, a_fwd_valid, a_fwd_last,
        output b_fwd_data, b_fwd_valid, b_fwd_last,
        output c_data, c_valid, err_last_mismatch
    );

endinterface

// File: rtl/systolic_fwd_reg.sv
// One-entry {data,last} forwarding register; 1-cycle latency from load to out_valid.
// Upstream must only load when the entry is empty or being drained this cycle.
module systolic_fwd_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/systolic_mac_pe.sv
// Systolic MAC cell: forwards A east / B south, 2-stage multiply-accumulate, result 3 cycles after last pair.
// Accepts only in ACC with no stalled forward entry; MAC_PE_SATURATE_EN selects saturating accumulation.
module systolic_mac_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W = SYS_DATA_W,
    parameter int ACC_W  = SYS_ACC_W
) (
    input  logic               clk,
    input  logic               rst,
    systolic_mac_pe_if.slave   bus
);

    localparam int PROD_W = 2 * DATA_W;

    generate
        if (ACC_W < 2 * DATA_W) begin : g_width_check
            $error("systolic_mac_pe: ACC_W must be at least 2*DATA_W");
        end
`ifdef MAC_PE_SATURATE_EN
        if (ACC_W > SYS_MAX_W) begin : g_sat_width_check
            $error("systolic_mac_pe: ACC_W exceeds saturating adder width");
        end
`endif
    endgenerate

    mac_state_t                state;
    logic                      fwd_stall;
    logic                      in_ready;
    logic                      fire;
    logic                      pair_last;
    logic signed [DATA_W-1:0]  a_s;
    logic signed [DATA_W-1:0]  b_s;
    logic signed [PROD_W-1:0]  prod;
    logic                      p_valid;
    logic                      p_last;
    logic                      drain_done;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_next;
    logic        [ACC_W-1:0]   c_data_q;
    logic                      c_valid_q;
    logic                      err_q;

    assign fwd_stall = (bus.a_fwd_valid & ~bus.a_fwd_ready) |
                       (bus.b_fwd_valid & ~bus.b_fwd_ready);
    assign in_ready  = (state == ACC) & ~fwd_stall;
    assign fire      = bus.a_valid & bus.b_valid & in_ready;
    assign pair_last = bus.a_last | bus.b_last;
    assign a_s       = bus.a_data;
    assign b_s       = bus.b_data;

    assign bus.in_ready          = in_ready;
    assign bus.c_data            = c_data_q;
    assign bus.c_valid           = c_valid_q;
    assign bus.err_last_mismatch = err_q;

    systolic_fwd_reg #(.W(DATA_W)) u_fwd_east (
        .clk       (clk),
        .rst       (rst),
        .load      (fire),
        .in_data   (bus.a_data),
        .in_last   (bus.a_last),
        .out_ready (bus.a_fwd_ready),
        .out_valid (bus.a_fwd_valid),
        .out_data  (bus.a_fwd_data),
        .out_last  (bus.a_fwd_last)
    );

    systolic_fwd_reg #(.W(DATA_W)) u_fwd_south (
        .clk       (clk),
        .rst       (rst),
        .load      (fire),
        .in_data   (bus.b_data),
        .in_last   (bus.b_last),
        .out_ready (bus.b_fwd_ready),
        .out_valid (bus.b_fwd_valid),
        .out_data  (bus.b_fwd_data),
        .out_last  (bus.b_fwd_last)
    );

    always_comb begin
        acc_next = acc;
`ifdef MAC_PE_SATURATE_EN
        acc_next = ACC_W'(sat_add(SYS_MAX_W'(acc), SYS_MAX_W'(prod), ACC_W));
`else
        acc_next = acc + ACC_W'(prod);
`endif
    end

    // drain_done marks the cycle after the last product entered acc, so OUT captures the final sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACC;
            prod       <= '0;
            p_valid    <= 1'b0;
            p_last     <= 1'b0;
            drain_done <= 1'b0;
            acc        <= '0;
            c_data_q   <= '0;
            c_valid_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            p_valid    <= fire;
            p_last     <= fire & pair_last;
            drain_done <= p_valid & p_last;
            if (fire) begin
                prod <= PROD_W'(a_s) * PROD_W'(b_s);
            end
            if (fire && (bus.a_last != bus.b_last)) begin
                err_q <= 1'b1;
            end
            if (p_valid) begin
                acc <= acc_next;
            end
            case (state)
                ACC: begin
                    if (fire && pair_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state     <= OUT;
                        c_data_q  <= acc;
                        c_valid_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (bus.c_ready) begin
                        state     <= ACC;
                        c_valid_q <= 1'b0;
                        acc       <= '0;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule
